// File: rtl/coefficient_pkg.sv
// Shared types and default coefficient table for the coefficient streamer.
package coefficient_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  localparam int unsigned DefaultLength = 20;

  localparam int COEFF_DEFAULT [DefaultLength] = '{
    34, 34, 0, 49, 125, -77, -51, 8, 97, 109,
    -91, -3, 9, 1, 59, 75, 19, 58, -97, 10
  };

  // Entries past the default table read as zero so any LENGTH is well defined.
  function automatic int coeff_default(input int unsigned idx);
    return (idx < DefaultLength) ? COEFF_DEFAULT[idx] : 0;
  endfunction

  function automatic int unsigned index_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/coefficient_rom.sv
// Coefficient table with combinational read. Define COEFF_WRITE_EN for a
// writable table (resets to the defaults); otherwise it is a constant ROM.
module coefficient_rom
  import coefficient_pkg::*;
#(
  parameter int unsigned LENGTH     = 20,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = index_width(LENGTH)
) (
`ifdef COEFF_WRITE_EN
  input  logic                         clock,
  input  logic                         resetN,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
`endif
  input  logic [ADDR_WIDTH-1:0]        rd_index,
  output logic signed [DATA_WIDTH-1:0] rd_data
);

`ifdef COEFF_WRITE_EN
  logic signed [DATA_WIDTH-1:0] mem_q [LENGTH];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int unsigned i = 0; i < LENGTH; i++) begin
        mem_q[i] <= DATA_WIDTH'(coeff_default(i));
      end
    end else if (wr_en && (32'(wr_addr) < LENGTH)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (32'(rd_index) < LENGTH) rd_data = mem_q[rd_index];
  end
`else
  always_comb begin
    rd_data = '0;
    if (32'(rd_index) < LENGTH) rd_data = DATA_WIDTH'(coeff_default(32'(rd_index)));
  end
`endif

endmodule

// File: rtl/coefficient_streamer.sv
// Streams LENGTH coefficients to a filter over valid/ready, forward or reversed.
// Define COEFF_WRITE_EN to add an IDLE-only table write port.
module coefficient_streamer
  import coefficient_pkg::*;
#(
  parameter int unsigned LENGTH     = 20,
  parameter int unsigned DATA_WIDTH = 8,
  localparam int unsigned ADDR_WIDTH = $clog2(LENGTH)
) (
  input  logic                         clock,
  input  logic                         resetN,
`ifdef COEFF_WRITE_EN
  input  logic                         wrEnable,
  input  logic [ADDR_WIDTH-1:0]        wrAddress,
  input  logic signed [DATA_WIDTH-1:0] wrData,
`endif
  input  logic                         start,
  input  logic                         reverse,
  input  logic                         coeffReady,
  output logic                         coeffValid,
  output logic signed [DATA_WIDTH-1:0] coefficientOut,
  output logic [ADDR_WIDTH-1:0]        coeffIndex,
  output logic                         busy,
  output logic                         filterSetFlag
);

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(LENGTH - 1);

  state_e                       state_q;
  logic [ADDR_WIDTH-1:0]        index_q;
  logic                         rev_q;
  logic                         at_last;
  logic signed [DATA_WIDTH-1:0] rom_data;

  assign at_last = rev_q ? (index_q == '0) : (index_q == LastIdx);

  coefficient_rom #(
    .LENGTH    (LENGTH),
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_rom (
`ifdef COEFF_WRITE_EN
    .clock   (clock),
    .resetN  (resetN),
    .wr_en   (wrEnable && (state_q == StIdle)),
    .wr_addr (wrAddress),
    .wr_data (wrData),
`endif
    .rd_index(index_q),
    .rd_data (rom_data)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q       <= StIdle;
      index_q       <= '0;
      rev_q         <= 1'b0;
      coeffValid    <= 1'b0;
      busy          <= 1'b0;
      filterSetFlag <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StLoad;
            rev_q      <= reverse;
            index_q    <= reverse ? LastIdx : '0;
            coeffValid <= 1'b1;
            busy       <= 1'b1;
          end
        end
        StLoad: begin
          if (coeffValid && coeffReady) begin
            if (at_last) begin
              state_q       <= StDone;
              coeffValid    <= 1'b0;
              filterSetFlag <= 1'b1;
            end else begin
              index_q <= rev_q ? index_q - ADDR_WIDTH'(1) : index_q + ADDR_WIDTH'(1);
            end
          end
        end
        StDone: begin
          state_q       <= StIdle;
          index_q       <= '0;
          busy          <= 1'b0;
          filterSetFlag <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Data and index read as zero whenever nothing is being offered.
  assign coefficientOut = coeffValid ? rom_data : '0;
  assign coeffIndex     = coeffValid ? index_q : '0;

endmodule

// File: tb/tb_coefficient_streamer.sv
// Randomised self-checking bench for coefficient_streamer against a table-order model.
module tb_coefficient_streamer;

  localparam int LEN = 20;
  localparam int DW  = 8;
  localparam int AW  = $clog2(LEN);

  logic                 clock = 1'b0;
  logic                 resetN, start, reverse, coeffReady;
  logic                 coeffValid, busy, filterSetFlag;
  logic signed [DW-1:0] coefficientOut;
  logic [AW-1:0]        coeffIndex;
`ifdef COEFF_WRITE_EN
  logic                 wrEnable;
  logic [AW-1:0]        wrAddress;
  logic signed [DW-1:0] wrData;
`endif

  coefficient_streamer #(.LENGTH(LEN), .DATA_WIDTH(DW)) dut (
    .clock         (clock),
    .resetN        (resetN),
`ifdef COEFF_WRITE_EN
    .wrEnable      (wrEnable),
    .wrAddress     (wrAddress),
    .wrData        (wrData),
`endif
    .start         (start),
    .reverse       (reverse),
    .coeffReady    (coeffReady),
    .coeffValid    (coeffValid),
    .coefficientOut(coefficientOut),
    .coeffIndex    (coeffIndex),
    .busy          (busy),
    .filterSetFlag (filterSetFlag)
  );

  always #5 clock = ~clock;

  int model_tab [LEN] = '{34, 34, 0, 49, 125, -77, -51, 8, 97, 109,
                          -91, -3, 9, 1, 59, 75, 19, 58, -97, 10};

  int vectors = 0;
  int miscompares = 0;

  int got_val[$];
  int got_idx[$];
  int flag_count, flag_cycle, first_valid, stall_err;
  bit timed_out;
  int ready_mode;        // 0 full rate, 1 pattern 1,0,0,1, 2 random
  int extra_start_at;    // transfer count at which to pulse start again (-1 none)
  bit start_in_done;
  bit wr_in_load;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs one load and records every accepted transfer; the tests do the checking.
  task automatic collect(input bit rev);
    int  c;
    bit  done, prev_stall, rdy;
    int  pv, pi;
    got_val.delete();
    got_idx.delete();
    flag_count = 0; flag_cycle = -1; first_valid = -1; stall_err = 0;
    prev_stall = 0; pv = 0; pi = 0; done = 0;
    start = 1'b1; reverse = rev;
    step();
    start = 1'b0;
    c = 1;
    while (!done && c < 400) begin
      start = 1'b0;
      if (filterSetFlag) begin
        flag_count++;
        if (flag_cycle < 0) flag_cycle = c;
        if (start_in_done) start = 1'b1;
      end
      if (coeffValid) begin
        if (first_valid < 0) first_valid = c;
        if (prev_stall && (int'(coefficientOut) != pv || int'(coeffIndex) != pi)) stall_err++;
        if (got_val.size() == extra_start_at) start = 1'b1;
      end
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (c % 4 == 1) || (c % 4 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      coeffReady = rdy;
      reverse = 1'($urandom_range(0, 1));
`ifdef COEFF_WRITE_EN
      wrEnable = wr_in_load && coeffValid;
      wrAddress = AW'(5);
      wrData = 8'sd99;
`endif
      if (coeffValid && rdy) begin
        got_val.push_back(int'(coefficientOut));
        got_idx.push_back(int'(coeffIndex));
      end
      prev_stall = coeffValid && !rdy;
      pv = int'(coefficientOut);
      pi = int'(coeffIndex);
      done = (flag_cycle >= 0) && (c >= flag_cycle + 2);
      step();
      c++;
    end
    start = 1'b0; coeffReady = 1'b0;
`ifdef COEFF_WRITE_EN
    wrEnable = 1'b0;
`endif
    timed_out = !done;
  endtask

  function automatic int exp_idx(input bit rev, input int n);
    return rev ? LEN - 1 - n : n;
  endfunction

  task automatic test_reset();
    resetN = 1'b0; start = 0; reverse = 0; coeffReady = 0;
`ifdef COEFF_WRITE_EN
    wrEnable = 0; wrAddress = '0; wrData = '0;
`endif
    #12;
    vectors++; if (coeffValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", coeffValid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (filterSetFlag !== 1'b0) begin miscompares++; $display("FAIL reset_flag: got %b expected 0", filterSetFlag); end
    vectors++; if (coefficientOut !== '0) begin miscompares++; $display("FAIL reset_data: got %0d expected 0", coefficientOut); end
    vectors++; if (coeffIndex !== '0) begin miscompares++; $display("FAIL reset_index: got %0d expected 0", coeffIndex); end
    step(); resetN = 1'b1; step(); step();
    vectors++; if (busy !== 1'b0 || coeffValid !== 1'b0) begin miscompares++; $display("FAIL idle_after_reset: busy %b valid %b expected 0 0", busy, coeffValid); end
  endtask

  task automatic check_load(input string name, input bit rev);
    vectors++;
    if (timed_out) begin miscompares++; $display("FAIL %s_timeout: got no flag expected flag within budget", name); end
    vectors++;
    if (got_val.size() != LEN) begin miscompares++; $display("FAIL %s_count: got %0d transfers expected %0d", name, got_val.size(), LEN); end
    for (int n = 0; n < got_val.size() && n < LEN; n++) begin
      vectors++;
      if (got_idx[n] != exp_idx(rev, n) || got_val[n] != model_tab[exp_idx(rev, n)]) begin
        miscompares++;
        $display("FAIL %s_xfer%0d: got idx %0d val %0d expected idx %0d val %0d", name, n,
                 got_idx[n], got_val[n], exp_idx(rev, n), model_tab[exp_idx(rev, n)]);
      end
    end
    vectors++;
    if (flag_count != 1) begin miscompares++; $display("FAIL %s_flag_pulses: got %0d expected 1", name, flag_count); end
    vectors++;
    if (stall_err != 0) begin miscompares++; $display("FAIL %s_stall_stable: got %0d changes expected 0", name, stall_err); end
    vectors++;
    if (busy !== 1'b0 || coeffValid !== 1'b0) begin miscompares++; $display("FAIL %s_idle_after: busy %b valid %b expected 0 0", name, busy, coeffValid); end
  endtask

  task automatic test_forward();
    ready_mode = 0; extra_start_at = -1; start_in_done = 0; wr_in_load = 0;
    collect(1'b0);
    check_load("forward", 1'b0);
    vectors++; if (first_valid != 1) begin miscompares++; $display("FAIL forward_latency: got %0d expected 1", first_valid); end
    vectors++; if (flag_cycle != LEN + 1) begin miscompares++; $display("FAIL forward_flag_cycle: got %0d expected %0d", flag_cycle, LEN + 1); end
  endtask

  task automatic test_reverse();
    ready_mode = 0; extra_start_at = -1; start_in_done = 0; wr_in_load = 0;
    collect(1'b1);
    check_load("reverse", 1'b1);
    vectors++; if (flag_cycle != LEN + 1) begin miscompares++; $display("FAIL reverse_flag_cycle: got %0d expected %0d", flag_cycle, LEN + 1); end
  endtask

  task automatic test_backpressure();
    ready_mode = 1; extra_start_at = -1; start_in_done = 0; wr_in_load = 0;
    collect(1'b0);
    check_load("backpressure", 1'b0);
  endtask

  task automatic test_random();
    bit rev;
    ready_mode = 2; extra_start_at = -1; start_in_done = 0; wr_in_load = 0;
    for (int k = 0; k < 4; k++) begin
      rev = 1'($urandom_range(0, 1));
      collect(rev);
      check_load("random", rev);
    end
  endtask

  task automatic test_start_ignored();
    ready_mode = 0; extra_start_at = 5; start_in_done = 1; wr_in_load = 0;
    collect(1'b0);
    check_load("start_ignored", 1'b0);
    step(); step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL done_start_ignored: got busy %b expected 0", busy); end
    extra_start_at = -1; start_in_done = 0;
  endtask

  task automatic test_abort();
    int flags;
    flags = 0;
    start = 1'b1; reverse = 1'b0; step(); start = 1'b0; coeffReady = 1'b1;
    repeat (7) step();
    vectors++; if (coeffValid !== 1'b1 || int'(coeffIndex) != 7) begin miscompares++; $display("FAIL abort_pre: got valid %b idx %0d expected 1 7", coeffValid, coeffIndex); end
    #2 resetN = 1'b0;
    #1;
    vectors++; if (coeffValid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL abort_async: got valid %b busy %b expected 0 0", coeffValid, busy); end
    vectors++; if (coefficientOut !== '0 || coeffIndex !== '0) begin miscompares++; $display("FAIL abort_outputs: got data %0d idx %0d expected 0 0", coefficientOut, coeffIndex); end
    coeffReady = 1'b0;
    repeat (3) begin step(); if (filterSetFlag) flags++; end
    resetN = 1'b1;
    repeat (2) begin step(); if (filterSetFlag) flags++; end
    vectors++; if (flags != 0) begin miscompares++; $display("FAIL abort_no_flag: got %0d flags expected 0", flags); end
    ready_mode = 0;
    collect(1'b0);
    check_load("restart", 1'b0);
  endtask

`ifdef COEFF_WRITE_EN
  task automatic test_write();
    wrEnable = 1'b1; wrAddress = AW'(3); wrData = -8'sd5; step();
    model_tab[3] = -5;
    wrAddress = AW'(25); wrData = 8'sd77; step();
    // Write and start together: the load must see the new value.
    wrAddress = AW'(0); wrData = -8'sd20;
    model_tab[0] = -20;
    ready_mode = 0; wr_in_load = 1;
    collect(1'b0);
    check_load("write_then_load", 1'b0);
    wr_in_load = 0;
    collect(1'b0);
    check_load("write_in_load_dropped", 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_backpressure();
    test_random();
    test_start_ignored();
    test_abort();
`ifdef COEFF_WRITE_EN
    test_write();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
